data_sramlike_ctrl: RTL and testbench
=====================================

Name: data_sramlike_ctrl

Overview:
Memory-stage data-bus controller that sits directly downstream of the M-stage load/store selector. It takes that selector's byte-enables, write data and address, and issues each access as one sram-like transaction (req/addr_ok/data_ok). It stalls the pipeline until the access completes and returns raw read data to the selector's r_data input. It also holds completed read data while the pipeline is frozen for other reasons, so an access is never reissued.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
mem_en  in  1  M-stage instruction is a load/store
mem_wen  in  4  byte enables from selector (0000 = load)
mem_addr  in  32  byte address
mem_wdata  in  32  replicated store data from selector
mem_size  in  2  0=byte 1=half 2=word
except_flush  in  1  M-stage exception (adel/ades/other); suppresses new request
pipe_stall  in  1  global stall from other sources (excluding dmem_stall)
mem_rdata  out  32  raw word to selector r_data
dmem_stall  out  1  stall request to hazard unit
data_req  out  1  sram-like request
data_wr  out  1  1=write
data_size  out  2  transfer size
data_addr  out  32  transfer address
data_wdata  out  32  write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  response valid
data_rdata  in  32  read data

Behaviour:
- States: IDLE, WAIT_DATA, DONE. Reset -> IDLE, rdata_r=0.
- Reset output values: data_req=0, dmem_stall=0, mem_rdata=0.
- Pass-throughs: data_addr=mem_addr, data_wdata=mem_wdata, data_size=mem_size, data_wr=|mem_wen. All are combinational; M inputs are stable while stalled.
- IDLE:
  - data_req = mem_en & ~except_flush.
  - dmem_stall = data_req.
  - data_addr_ok & data_req -> WAIT_DATA.
  - Request without addr_ok stays in IDLE with req held.
- WAIT_DATA:
  - data_req=0, dmem_stall = ~data_data_ok.
  - On data_data_ok, rdata_r <= data_rdata, and mem_rdata = data_rdata (same-cycle bypass).
  - Next state is DONE if pipe_stall, else IDLE.
- DONE:
  - data_req=0, dmem_stall=0, mem_rdata=rdata_r.
  - ~pipe_stall -> IDLE.
  - No reissue while in DONE, even though mem_en is still high.
- mem_rdata = rdata_r in all cases except the WAIT_DATA bypass.
- Slave contract: data_ok arrives at least 1 cycle after addr_ok. At most one transaction is outstanding.
- except_flush in IDLE before addr_ok: req drops that cycle, no transaction.
- except_flush in WAIT_DATA: the accepted transaction is always drained. Stall is held until data_ok, and the response is discarded (rdata_r still written, harmless).
- Writes follow the same path; data_ok completes a write, and rdata is ignored downstream.
- Reset mid-transaction: returns to IDLE next edge. The interconnect shares rst, so the outstanding response is dropped system-wide.
- pipe_stall rising while in IDLE with a request has no effect on issue; the request proceeds.

Decomposition:
- Shared package/defines: state encodings (IDLE=2'd0, WAIT_DATA=2'd1, DONE=2'd2) and size codes (SIZE_B/H/W).
- No sub-module; single flat FSM plus one 32-bit data register.

Test Plan:
- LW at 0x1000_0004, addr_ok in cycle 0, data_ok in cycle 2 with data 0xDEADBEEF, pipe_stall=0:
  - data_req=1 only in cycle 0, size=2, wr=0.
  - dmem_stall high cycles 0-1, low in cycle 2.
  - mem_rdata=0xDEADBEEF in cycle 2.
  - IDLE in cycle 3.
- SB, mem_wen=0010, addr 0x...01, size=0, addr_ok delayed 3 cycles:
  - req held 4 cycles with stable addr/wdata, wr=1.
  - Stall released on data_ok.
- LW completes while pipe_stall=1 for 3 cycles:
  - DONE entered; mem_rdata holds 0x12345678.
  - data_req stays 0 and dmem_stall=0 throughout.
  - IDLE after pipe_stall falls.
- except_flush=1 with mem_en=1 in IDLE -> data_req=0, dmem_stall=0, state stays IDLE.
- except_flush asserted in WAIT_DATA -> dmem_stall stays 1 until data_ok, then IDLE; no new req that cycle.
- rst asserted in WAIT_DATA -> next cycle IDLE, data_req=0, dmem_stall=0, mem_rdata=0.

Source files
------------

// File: rtl/data_sramlike_ctrl_pkg.sv
// data_sramlike_ctrl_pkg
// Shared constants for the M-stage sram-like data-bus controller.
//   - FSM state encodings (IDLE / WAIT_DATA / DONE)
//   - transfer size codes carried on data_size
package data_sramlike_ctrl_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_DATA = 2'd1;
   localparam logic [1:0] ST_DONE      = 2'd2;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/data_sramlike_ctrl.sv
// data_sramlike_ctrl
// Issues each M-stage load/store as a single sram-like transaction,
// stalls the pipeline until it completes, and holds the returned word
// while the pipeline is frozen by other sources so no access is reissued.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transaction outstanding; request issued from M inputs
// WAIT_DATA | address accepted, waiting for data_ok (always drained)
// DONE      | access complete, pipeline frozen elsewhere; hold rdata_r
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_en, mem_wen, mem_addr,
//   mem_wdata, mem_size       access from the M-stage load/store selector
//   except_flush              M-stage exception, blocks a new request
//   pipe_stall                stall from sources other than dmem_stall
//   mem_rdata                 raw read word back to the selector
//   dmem_stall                stall request to the hazard unit
//   data_*                    sram-like master interface
module data_sramlike_ctrl
   import data_sramlike_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_en,
   input  logic [3:0]        mem_wen,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [1:0]        mem_size,
   input  logic              except_flush,
   input  logic              pipe_stall,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              dmem_stall,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata
);

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [DATA_W-1:0] rdata_r;
   logic              issue;

   // M-stage inputs are frozen while stalled, so these stay stable for
   // the whole handshake without extra registering.
   assign data_addr  = mem_addr;
   assign data_wdata = mem_wdata;
   assign data_size  = mem_size;
   assign data_wr    = |mem_wen;

   assign issue = (state_q == ST_IDLE) & mem_en & ~except_flush;

   always_comb begin
      state_d    = state_q;
      data_req   = 1'b0;
      dmem_stall = 1'b0;
      mem_rdata  = rdata_r;
      case (state_q)
         ST_IDLE: begin
            data_req   = issue;
            dmem_stall = issue;
            if (issue && data_addr_ok)
               state_d = ST_WAIT_DATA;
         end
         ST_WAIT_DATA: begin
            // A flush here does not abort: the slave already accepted the
            // address, so the response must be drained before moving on.
            dmem_stall = ~data_data_ok;
            if (data_data_ok) begin
               mem_rdata = data_rdata;
               state_d   = pipe_stall ? ST_DONE : ST_IDLE;
            end
         end
         ST_DONE: begin
            // mem_en is still high here; parking avoids a duplicate access.
            if (!pipe_stall)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rdata_r <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_WAIT_DATA && data_data_ok)
            rdata_r <= data_rdata;
      end
   end

endmodule

// File: tb/tb_data_sramlike_ctrl.sv
module tb_data_sramlike_ctrl;
   import data_sramlike_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_size;
   logic        except_flush;
   logic        pipe_stall;
   logic [31:0] mem_rdata;
   logic        dmem_stall;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   int checks   = 0;
   int failures = 0;

   data_sramlike_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_en       (mem_en),
      .mem_wen      (mem_wen),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_size     (mem_size),
      .except_flush (except_flush),
      .pipe_stall   (pipe_stall),
      .mem_rdata    (mem_rdata),
      .dmem_stall   (dmem_stall),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to just after the next rising edge (inputs are driven here)
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // sample point, half a period away from the active edge
   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      mem_en       = 1'b0;
      mem_wen      = 4'b0000;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      mem_size     = SIZE_W;
      except_flush = 1'b0;
      pipe_stall   = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      smp();
      checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", data_req); end
      checks++; if (dmem_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", dmem_stall); end
      checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", mem_rdata); end
      checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_lw();
      mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h1000_0004; mem_size = SIZE_W;
      data_addr_ok = 1'b1;
      smp();
      checks++; if (data_req !== 1'b1) begin failures++; $display("FAIL lw_req_c0 got=%0b exp=1", data_req); end
      checks++; if (data_wr !== 1'b0) begin failures++; $display("FAIL lw_wr got=%0b exp=0", data_wr); end
      checks++; if (data_size !== 2'd2) begin failures++; $display("FAIL lw_size got=%0d exp=2", data_size); end
      checks++; if (data_addr !== 32'h1000_0004) begin failures++; $display("FAIL lw_addr got=%h exp=10000004", data_addr); end
      checks++; if (dmem_stall !== 1'b1) begin failures++; $display("FAIL lw_stall_c0 got=%0b exp=1", dmem_stall); end
      cyc();
      data_addr_ok = 1'b0;
      smp();
      checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL lw_req_c1 got=%0b exp=0", data_req); end
      checks++; if (dmem_stall !== 1'b1) begin failures++; $display("FAIL lw_stall_c1 got=%0b exp=1", dmem_stall); end
      cyc();
      data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
      smp();
      checks++; if (dmem_stall !== 1'b0) begin failures++; $display("FAIL lw_stall_c2 got=%0b exp=0", dmem_stall); end
      checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_bypass got=%h exp=deadbeef", mem_rdata); end
      checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL lw_req_c2 got=%0b exp=0", data_req); end
      cyc();
      data_data_ok = 1'b0; data_rdata = 32'h0; mem_en = 1'b0;
      smp();
      checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL lw_state_c3 got=%0d exp=%0d", dut.state_q, ST_IDLE); end
      checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_hold_c3 got=%h exp=deadbeef", mem_rdata); end
      idle_inputs();
   endtask

   task automatic test_sb();
      mem_en = 1'b1; mem_wen = 4'b0010; mem_addr = 32'h8000_0001;
      mem_wdata = 32'h5A5A_5A5A; mem_size = SIZE_B;
      for (int i = 0; i < 4; i++) begin
         data_addr_ok = (i == 3);
         smp();
         checks++; if (data_req !== 1'b1) begin failures++; $display("FAIL sb_req_c%0d got=%0b exp=1", i, data_req); end
         checks++; if (data_wr !== 1'b1) begin failures++; $display("FAIL sb_wr_c%0d got=%0b exp=1", i, data_wr); end
         checks++; if (data_addr !== 32'h8000_0001 || data_wdata !== 32'h5A5A_5A5A || data_size !== 2'd0) begin
            failures++; $display("FAIL sb_bus_c%0d got=%h/%h/%0d exp=80000001/5a5a5a5a/0", i, data_addr, data_wdata, data_size); end
         checks++; if (dmem_stall !== 1'b1) begin failures++; $display("FAIL sb_stall_c%0d got=%0b exp=1", i, dmem_stall); end
         cyc();
      end
      data_addr_ok = 1'b0;
      smp();
      checks++; if (data_req !== 1'b0 || dmem_stall !== 1'b1) begin
         failures++; $display("FAIL sb_wait got=req%0b/stall%0b exp=req0/stall1", data_req, dmem_stall); end
      cyc();
      data_data_ok = 1'b1;
      smp();
      checks++; if (dmem_stall !== 1'b0) begin failures++; $display("FAIL sb_release got=%0b exp=0", dmem_stall); end
      cyc();
      idle_inputs();
      smp();
      checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL sb_state_end got=%0d exp=%0d", dut.state_q, ST_IDLE); end
   endtask

   task automatic test_pipe_stall();
      mem_en = 1'b1; mem_addr = 32'h2000_0000; mem_size = SIZE_W;
      data_addr_ok = 1'b1;
      smp();
      cyc();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678; pipe_stall = 1'b1;
      smp();
      checks++; if (mem_rdata !== 32'h1234_5678) begin failures++; $display("FAIL ps_bypass got=%h exp=12345678", mem_rdata); end
      checks++; if (dmem_stall !== 1'b0) begin failures++; $display("FAIL ps_stall_c1 got=%0b exp=0", dmem_stall); end
      cyc();
      data_data_ok = 1'b0; data_rdata = 32'hFFFF_FFFF;
      for (int i = 2; i < 4; i++) begin
         smp();
         checks++; if (dut.state_q !== ST_DONE) begin failures++; $display("FAIL ps_state_c%0d got=%0d exp=%0d", i, dut.state_q, ST_DONE); end
         checks++; if (data_req !== 1'b0 || dmem_stall !== 1'b0) begin
            failures++; $display("FAIL ps_quiet_c%0d got=req%0b/stall%0b exp=req0/stall0", i, data_req, dmem_stall); end
         checks++; if (mem_rdata !== 32'h1234_5678) begin failures++; $display("FAIL ps_hold_c%0d got=%h exp=12345678", i, mem_rdata); end
         cyc();
      end
      pipe_stall = 1'b0;
      smp();
      checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL ps_noreissue got=%0b exp=0", data_req); end
      cyc();
      idle_inputs();
      smp();
      checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL ps_state_end got=%0d exp=%0d", dut.state_q, ST_IDLE); end
   endtask

   task automatic test_flush_idle();
      mem_en = 1'b1; except_flush = 1'b1; data_addr_ok = 1'b1;
      smp();
      checks++; if (data_req !== 1'b0 || dmem_stall !== 1'b0) begin
         failures++; $display("FAIL fi_quiet got=req%0b/stall%0b exp=req0/stall0", data_req, dmem_stall); end
      cyc();
      smp();
      checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL fi_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_flush_wait();
      mem_en = 1'b1; mem_addr = 32'h0000_0040; data_addr_ok = 1'b1;
      smp();
      checks++; if (data_req !== 1'b1) begin failures++; $display("FAIL fw_req_c0 got=%0b exp=1", data_req); end
      cyc();
      data_addr_ok = 1'b0; except_flush = 1'b1;
      smp();
      checks++; if (data_req !== 1'b0 || dmem_stall !== 1'b1) begin
         failures++; $display("FAIL fw_c1 got=req%0b/stall%0b exp=req0/stall1", data_req, dmem_stall); end
      cyc();
      smp();
      checks++; if (dmem_stall !== 1'b1) begin failures++; $display("FAIL fw_stall_c2 got=%0b exp=1", dmem_stall); end
      cyc();
      data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
      smp();
      checks++; if (data_req !== 1'b0 || dmem_stall !== 1'b0) begin
         failures++; $display("FAIL fw_drain got=req%0b/stall%0b exp=req0/stall0", data_req, dmem_stall); end
      cyc();
      idle_inputs();
      smp();
      checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL fw_state_end got=%0d exp=%0d", dut.state_q, ST_IDLE); end
      checks++; if (mem_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL fw_rdata_r got=%h exp=cafef00d", mem_rdata); end
   endtask

   task automatic test_back_to_back();
      mem_en = 1'b1; mem_addr = 32'h3000_0000; data_addr_ok = 1'b1;
      smp();
      cyc();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
      smp();
      checks++; if (mem_rdata !== 32'h1111_1111) begin failures++; $display("FAIL b2b_first got=%h exp=11111111", mem_rdata); end
      cyc();
      data_data_ok = 1'b0; mem_addr = 32'h3000_0008; data_addr_ok = 1'b1;
      smp();
      checks++; if (data_req !== 1'b1 || data_addr !== 32'h3000_0008) begin
         failures++; $display("FAIL b2b_issue got=req%0b/%h exp=req1/30000008", data_req, data_addr); end
      cyc();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h2222_2222;
      smp();
      checks++; if (mem_rdata !== 32'h2222_2222 || dmem_stall !== 1'b0) begin
         failures++; $display("FAIL b2b_second got=%h/stall%0b exp=22222222/stall0", mem_rdata, dmem_stall); end
      cyc();
      idle_inputs();
      smp();
      checks++; if (mem_rdata !== 32'h2222_2222) begin failures++; $display("FAIL b2b_hold got=%h exp=22222222", mem_rdata); end
   endtask

   task automatic test_reset_mid();
      mem_en = 1'b1; mem_addr = 32'h4000_0000; data_addr_ok = 1'b1;
      smp();
      cyc();
      data_addr_ok = 1'b0; mem_en = 1'b0; rst = 1'b1;
      smp();
      checks++; if (dmem_stall !== 1'b1) begin failures++; $display("FAIL rm_wait_stall got=%0b exp=1", dmem_stall); end
      cyc();
      rst = 1'b0;
      smp();
      checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL rm_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
      checks++; if (data_req !== 1'b0 || dmem_stall !== 1'b0) begin
         failures++; $display("FAIL rm_quiet got=req%0b/stall%0b exp=req0/stall0", data_req, dmem_stall); end
      checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL rm_rdata got=%h exp=00000000", mem_rdata); end
      cyc();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_lw();
      test_sb();
      test_pipe_stall();
      test_flush_idle();
      test_flush_wait();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
